// File: rtl/TauCfg.sv
// Shared read-pipeline configuration.
// Widths and command encodings common to the chunk looper stages.
package TauCfg;

  localparam int GLOBAL_ADDR_BW = 32;
  localparam int CACHE_SIZE     = 16;
  localparam int VSIZE          = 8;
  localparam int DRAM_MAX_LINES = 4;

  typedef enum logic [1:0] {
    CMD_FETCH = 2'd0,
    CMD_REPL  = 2'd1,
    CMD_PAD   = 2'd2
  } ChunkCmdType;

endpackage

// File: rtl/forward_slice.sv
// One-entry registered rdy/ack stage.
// Loads whenever the held entry is empty or leaving this cycle.
module forward_slice #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         in_vld,
  input  logic [W-1:0] i_data,
  output logic         in_free,
  output logic         out_rdy,
  input  logic         out_ack,
  output logic [W-1:0] o_data
);

  assign in_free = !out_rdy || out_ack;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      out_rdy <= 1'b0;
      o_data  <= '0;
    end else if (in_free) begin
      out_rdy <= in_vld;
      if (in_vld) o_data <= i_data;
    end
  end

endmodule

// File: rtl/chunk_cmd_dispatch.sv
// Splits chunk commands into coalesced DRAM line reads
// and allocation descriptors for the aligner.
module chunk_cmd_dispatch
  import TauCfg::*;
#(
  parameter int GBW       = GLOBAL_ADDR_BW,
  parameter int CSIZE     = CACHE_SIZE,
  parameter int VSIZE     = TauCfg::VSIZE,
  parameter int MAX_LINES = DRAM_MAX_LINES,
  localparam int C_BW     = $clog2(CSIZE),
  localparam int V_BW1    = $clog2(VSIZE + 1),
  localparam int CR_BW    = $clog2(MAX_LINES + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             cmd_rdy,
  output logic             cmd_ack,
  input  logic [1:0]       i_cmd_type,
  input  logic             i_cmd_islast,
  input  logic [GBW-1:0]   i_cmd_addr,
  input  logic [C_BW-1:0]  i_cmd_addrofs,
  input  logic [V_BW1-1:0] i_cmd_len,
  output logic             dramra_rdy,
  input  logic             dramra_ack,
  output logic [GBW-1:0]   o_dramra_addr,
  output logic             alloc_rdy,
  input  logic             alloc_ack,
  output logic [1:0]       o_alloc_type,
  output logic [C_BW-1:0]  o_alloc_ofs,
  output logic [V_BW1-1:0] o_alloc_len,
  output logic             o_alloc_newline,
  output logic             o_alloc_islast,
  input  logic             i_line_free
);

  localparam int AW = 2 + C_BW + V_BW1 + 2;
  localparam logic [CR_BW-1:0] CR_MAX = CR_BW'(MAX_LINES);

  logic [GBW-1:0]   last_line;
  logic             last_vld;
  logic [CR_BW-1:0] credit;

  logic          need_line;
  logic          accept;
  logic          inc;
  logic          dec;
  logic          alloc_free;
  logic          dramra_free;
  logic [AW-1:0] alloc_d;
  logic [AW-1:0] alloc_q;

  assign need_line = (i_cmd_type != CMD_PAD) &&
                     !(last_vld && (i_cmd_addr == last_line));

  // Credit check uses the registered count only.
  assign cmd_ack = !i_rst && cmd_rdy && alloc_free &&
                   (!need_line ||
                    (dramra_free && (credit < CR_MAX)));

  assign accept = cmd_ack;
  assign inc    = accept && need_line;
  assign dec    = i_line_free && (credit != '0);

  assign alloc_d = {i_cmd_type, i_cmd_addrofs, i_cmd_len,
                    need_line, i_cmd_islast};

  assign {o_alloc_type, o_alloc_ofs, o_alloc_len,
          o_alloc_newline, o_alloc_islast} = alloc_q;

  forward_slice #(.W(AW)) u_alloc (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .in_vld  (accept),
    .i_data  (alloc_d),
    .in_free (alloc_free),
    .out_rdy (alloc_rdy),
    .out_ack (alloc_ack),
    .o_data  (alloc_q)
  );

  forward_slice #(.W(GBW)) u_dramra (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .in_vld  (inc),
    .i_data  (i_cmd_addr),
    .in_free (dramra_free),
    .out_rdy (dramra_rdy),
    .out_ack (dramra_ack),
    .o_data  (o_dramra_addr)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      last_line <= '0;
      last_vld  <= 1'b0;
    end else if (accept) begin
      if (need_line) last_line <= i_cmd_addr;
      if (i_cmd_islast) last_vld <= 1'b0;
      else if (need_line) last_vld <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      credit <= '0;
    end else begin
      unique case (1'b1)
        inc && !dec: credit <= credit + CR_BW'(1);
        dec && !inc: credit <= credit - CR_BW'(1);
        default:     credit <= credit;
      endcase
    end
  end

endmodule

// File: tb/tb_chunk_cmd_dispatch.sv
// Directed bench for chunk_cmd_dispatch.
// Expected values are hand-derived per step.
module tb_chunk_cmd_dispatch;
  import TauCfg::*;

  logic        clk;
  logic        rst;
  logic        cmd_rdy;
  logic        cmd_ack;
  logic [1:0]  c_type;
  logic        c_last;
  logic [31:0] c_addr;
  logic [3:0]  c_ofs;
  logic [3:0]  c_len;
  logic        dramra_rdy;
  logic        dramra_ack;
  logic [31:0] dramra_addr;
  logic        alloc_rdy;
  logic        alloc_ack;
  logic [1:0]  a_type;
  logic [3:0]  a_ofs;
  logic [3:0]  a_len;
  logic        a_nl;
  logic        a_last;
  logic        line_free;

  int errs  = 0;
  int nchk  = 0;
  int mcred = 0;

  chunk_cmd_dispatch dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .cmd_rdy         (cmd_rdy),
    .cmd_ack         (cmd_ack),
    .i_cmd_type      (c_type),
    .i_cmd_islast    (c_last),
    .i_cmd_addr      (c_addr),
    .i_cmd_addrofs   (c_ofs),
    .i_cmd_len       (c_len),
    .dramra_rdy      (dramra_rdy),
    .dramra_ack      (dramra_ack),
    .o_dramra_addr   (dramra_addr),
    .alloc_rdy       (alloc_rdy),
    .alloc_ack       (alloc_ack),
    .o_alloc_type    (a_type),
    .o_alloc_ofs     (a_ofs),
    .o_alloc_len     (a_len),
    .o_alloc_newline (a_nl),
    .o_alloc_islast  (a_last),
    .i_line_free     (line_free)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst) begin
      assert (!(line_free && mcred == 0)) else begin
        errs++;
        $error("FAIL illegal_free: observed=1 expected=0");
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [1:0] t,
                     input logic l,
                     input logic [31:0] a,
                     input logic [3:0] o,
                     input logic [3:0] n);
    c_type  = t;
    c_last  = l;
    c_addr  = a;
    c_ofs   = o;
    c_len   = n;
    cmd_rdy = 1'b1;
  endtask

  task automatic send(input string tag,
                      input logic [1:0] t,
                      input logic l,
                      input logic [31:0] a,
                      input logic [3:0] o,
                      input logic [3:0] n,
                      input logic ack,
                      input logic nl);
    put(t, l, a, o, n);
    #1;
    chk({tag, "_ack"}, 32'(cmd_ack), 32'(ack));
    tick();
    cmd_rdy = 1'b0;
    if (ack && nl) mcred++;
  endtask

  task automatic chk_out(input string tag,
                         input logic dv,
                         input logic [31:0] da,
                         input logic av,
                         input logic [1:0] t,
                         input logic [3:0] o,
                         input logic [3:0] n,
                         input logic nl,
                         input logic l);
    chk({tag, "_dv"}, 32'(dramra_rdy), 32'(dv));
    if (dv) chk({tag, "_daddr"}, dramra_addr, da);
    chk({tag, "_av"}, 32'(alloc_rdy), 32'(av));
    if (av) begin
      chk({tag, "_type"}, 32'(a_type), 32'(t));
      chk({tag, "_ofs"}, 32'(a_ofs), 32'(o));
      chk({tag, "_len"}, 32'(a_len), 32'(n));
      chk({tag, "_nl"}, 32'(a_nl), 32'(nl));
      chk({tag, "_last"}, 32'(a_last), 32'(l));
    end
  endtask

  task automatic free();
    line_free = 1'b1;
    tick();
    line_free = 1'b0;
    mcred--;
  endtask

  initial begin
    rst        = 1'b1;
    cmd_rdy    = 1'b0;
    c_type     = 2'd0;
    c_last     = 1'b0;
    c_addr     = '0;
    c_ofs      = '0;
    c_len      = '0;
    dramra_ack = 1'b1;
    alloc_ack  = 1'b1;
    line_free  = 1'b0;

    put(CMD_FETCH, 1'b0, 32'h100, 4'd0, 4'd8);
    tick();
    tick();
    chk("rst_ack", 32'(cmd_ack), 32'h0);
    chk("rst_dv", 32'(dramra_rdy), 32'h0);
    chk("rst_av", 32'(alloc_rdy), 32'h0);
    chk("rst_daddr", dramra_addr, 32'h0);
    chk("rst_alloc",
        32'({a_type, a_ofs, a_len, a_nl, a_last}), 32'h0);
    cmd_rdy = 1'b0;
    rst     = 1'b0;
    tick();

    send("c1", CMD_FETCH, 0, 32'h100, 0, 8, 1, 1);
    chk_out("c1", 1, 32'h100, 1, CMD_FETCH, 0, 8, 1, 0);
    send("c2", CMD_FETCH, 0, 32'h100, 8, 8, 1, 0);
    chk_out("c2", 0, 0, 1, CMD_FETCH, 8, 8, 0, 0);
    send("c3", CMD_FETCH, 0, 32'h140, 0, 8, 1, 1);
    chk_out("c3", 1, 32'h140, 1, CMD_FETCH, 0, 8, 1, 0);
    tick();
    chk_out("c_idle", 0, 0, 0, 0, 0, 0, 0, 0);
    free();
    free();

    send("p1", CMD_FETCH, 0, 32'h200, 2, 4, 1, 1);
    chk_out("p1", 1, 32'h200, 1, CMD_FETCH, 2, 4, 1, 0);
    send("p2", CMD_PAD, 0, 32'h500, 0, 3, 1, 0);
    chk_out("p2", 0, 0, 1, CMD_PAD, 0, 3, 0, 0);
    send("p3", CMD_REPL, 0, 32'h200, 6, 2, 1, 0);
    chk_out("p3", 0, 0, 1, CMD_REPL, 6, 2, 0, 0);
    send("p4", CMD_FETCH, 0, 32'h200, 0, 0, 1, 0);
    chk_out("p4", 0, 0, 1, CMD_FETCH, 0, 0, 0, 0);

    send("b1", CMD_FETCH, 1, 32'h300, 0, 8, 1, 1);
    chk_out("b1", 1, 32'h300, 1, CMD_FETCH, 0, 8, 1, 1);
    send("b2", CMD_FETCH, 0, 32'h300, 0, 8, 1, 1);
    chk_out("b2", 1, 32'h300, 1, CMD_FETCH, 0, 8, 1, 0);
    tick();
    free();
    free();
    free();

    for (int i = 0; i < 4; i++) begin
      send("k", CMD_FETCH, 0, 32'h400 + 32'(i * 64), 0, 8, 1, 1);
      chk_out("k", 1, 32'h400 + 32'(i * 64),
              1, CMD_FETCH, 0, 8, 1, 0);
    end
    put(CMD_FETCH, 1'b0, 32'h500, 4'd0, 4'd8);
    #1;
    chk("stall0_ack", 32'(cmd_ack), 32'h0);
    tick();
    chk("stall1_ack", 32'(cmd_ack), 32'h0);
    line_free = 1'b1;
    #1;
    chk("free_same_cyc_ack", 32'(cmd_ack), 32'h0);
    tick();
    line_free = 1'b0;
    mcred--;
    #1;
    chk("after_free_ack", 32'(cmd_ack), 32'h1);
    tick();
    cmd_rdy = 1'b0;
    mcred++;
    chk_out("k5", 1, 32'h500, 1, CMD_FETCH, 0, 8, 1, 0);
    free();
    put(CMD_FETCH, 1'b0, 32'h580, 4'd0, 4'd8);
    line_free = 1'b1;
    #1;
    chk("simul_ack", 32'(cmd_ack), 32'h1);
    tick();
    line_free = 1'b0;
    cmd_rdy   = 1'b0;
    chk_out("simul", 1, 32'h580, 1, CMD_FETCH, 0, 8, 1, 0);
    send("k7", CMD_FETCH, 0, 32'h5C0, 0, 8, 1, 1);
    send("k8", CMD_FETCH, 0, 32'h600, 0, 8, 0, 1);
    tick();
    free();
    free();
    free();
    free();

    alloc_ack = 1'b0;
    send("bp1", CMD_FETCH, 0, 32'h700, 1, 5, 1, 1);
    chk_out("bp1", 1, 32'h700, 1, CMD_FETCH, 1, 5, 1, 0);
    put(CMD_FETCH, 1'b0, 32'h740, 4'd2, 4'd3);
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold_ack", 32'(cmd_ack), 32'h0);
      chk("bp_hold_av", 32'(alloc_rdy), 32'h1);
      chk("bp_hold_data", 32'({a_ofs, a_len}), 32'h15);
      tick();
    end
    chk("bp_dv_drained", 32'(dramra_rdy), 32'h0);
    alloc_ack = 1'b1;
    #1;
    chk("bp_release_ack", 32'(cmd_ack), 32'h1);
    tick();
    cmd_rdy = 1'b0;
    mcred++;
    chk_out("bp2", 1, 32'h740, 1, CMD_FETCH, 2, 3, 1, 0);
    tick();
    chk_out("bp_idle", 0, 0, 0, 0, 0, 0, 0, 0);
    free();
    free();

    dramra_ack = 1'b0;
    alloc_ack  = 1'b0;
    send("r1", CMD_FETCH, 0, 32'h800, 3, 4, 1, 1);
    tick();
    chk_out("r_held", 1, 32'h800, 1, CMD_FETCH, 3, 4, 1, 0);
    rst = 1'b1;
    tick();
    rst   = 1'b0;
    mcred = 0;
    chk("r_dv", 32'(dramra_rdy), 32'h0);
    chk("r_av", 32'(alloc_rdy), 32'h0);
    chk("r_daddr", dramra_addr, 32'h0);
    chk("r_alloc",
        32'({a_type, a_ofs, a_len, a_nl, a_last}), 32'h0);
    dramra_ack = 1'b1;
    alloc_ack  = 1'b1;
    send("r2", CMD_FETCH, 0, 32'h800, 0, 8, 1, 1);
    chk_out("r2", 1, 32'h800, 1, CMD_FETCH, 0, 8, 1, 0);
    send("r3", CMD_FETCH, 0, 32'h840, 0, 8, 1, 1);
    send("r4", CMD_FETCH, 0, 32'h880, 0, 8, 1, 1);
    send("r5", CMD_FETCH, 0, 32'h8C0, 0, 8, 1, 1);
    send("r6", CMD_FETCH, 0, 32'h900, 0, 8, 0, 1);
    tick();
    free();
    free();
    free();
    free();

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
